// File: rtl/uart_token_parser.sv
// uart_token_parser: turns console bytes into up to MAX_TOKENS unsigned
// integers per line, holding each line until line_ack.
// Ports: clk, rst (sync, active high), rx_data/rx_valid byte strobe in;
// line_valid/line_ack hold handshake; line_error, err_code, token_count,
// tokens line contents; overrun pulses for each byte dropped in hold.
// Option: define UART_TOKEN_PARSER_HEX_EN to accept 0x/0X hex tokens.
module uart_token_parser #(
    parameter int MAX_TOKENS  = 4,
    parameter int VALUE_WIDTH = 16
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [7:0]                        rx_data,
    input  logic                              rx_valid,
    output logic                              line_valid,
    input  logic                              line_ack,
    output logic                              line_error,
    output logic [1:0]                        err_code,
    output logic [$clog2(MAX_TOKENS+1)-1:0]   token_count,
    output logic [MAX_TOKENS*VALUE_WIDTH-1:0] tokens,
    output logic                              overrun
);
    localparam int CW = $clog2(MAX_TOKENS + 1);
    localparam int AW = VALUE_WIDTH + 4;
    localparam int TW = MAX_TOKENS * VALUE_WIDTH;

    localparam logic [1:0] E_OVF = 2'b01;
    localparam logic [1:0] E_CNT = 2'b10;
    localparam logic [1:0] E_ILL = 2'b11;

    typedef enum logic [2:0] {
        S_GAP,
        S_DEC,
`ifdef UART_TOKEN_PARSER_HEX_EN
        S_PFX,
        S_HEX,
`endif
        S_DISCARD,
        S_HOLD
    } state_t;

    state_t state_q, state_d, st;

    logic [VALUE_WIDTH-1:0] acc_q, acc_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [TW-1:0]          tok_q, tok_d;
    logic                   err_q, err_d;
    logic [1:0]             code_q, code_d;
    logic                   ovr_q, ovr_d;

    logic          is_dig, is_sep, is_term;
    logic          close, fail;
    logic [1:0]    fail_code;
    logic [AW-1:0] dec_ext;
    logic          dec_ovf;

    assign is_dig  = (rx_data >= 8'h30) && (rx_data <= 8'h39);
    assign is_sep  = (rx_data == 8'h20) || (rx_data == 8'h09);
    assign is_term = (rx_data == 8'h0A) || (rx_data == 8'h0D);

    // Wide enough that acc*10+9 never wraps; any bit above
    // VALUE_WIDTH means the token no longer fits.
    assign dec_ext = AW'(acc_q) * AW'(10) + AW'(rx_data[3:0]);
    assign dec_ovf = |dec_ext[AW-1:VALUE_WIDTH];

`ifdef UART_TOKEN_PARSER_HEX_EN
    logic          hexd_q, hexd_d;
    logic          is_x, is_alpha;
    logic [3:0]    nib;
    logic [AW-1:0] hex_ext;
    logic          hex_ovf;

    assign is_x     = (rx_data == 8'h78) || (rx_data == 8'h58);
    assign is_alpha = ((rx_data >= 8'h61) && (rx_data <= 8'h66))
                   || ((rx_data >= 8'h41) && (rx_data <= 8'h46));
    // Low nibble of 'a'/'A' is 1, so +9 maps the letters to 10..15.
    assign nib      = is_alpha ? rx_data[3:0] + 4'd9 : rx_data[3:0];
    assign hex_ext  = {acc_q, nib};
    assign hex_ovf  = |acc_q[VALUE_WIDTH-1 -: 4];
`endif

    always_comb begin
        state_d   = state_q;
        st        = state_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        tok_d     = tok_q;
        err_d     = err_q;
        code_d    = code_q;
        ovr_d     = 1'b0;
        close     = 1'b0;
        fail      = 1'b0;
        fail_code = 2'b00;
`ifdef UART_TOKEN_PARSER_HEX_EN
        hexd_d    = hexd_q;
`endif

        // An ack releases the held line in the same cycle, so a byte
        // arriving alongside it starts the next line from a clean GAP.
        if (state_q == S_HOLD && line_ack) begin
            st      = S_GAP;
            state_d = S_GAP;
            acc_d   = '0;
            cnt_d   = '0;
            tok_d   = '0;
            err_d   = 1'b0;
            code_d  = 2'b00;
        end

        if (rx_valid) begin
            unique case (st)
                S_GAP: begin
                    if (is_dig) begin
                        acc_d = VALUE_WIDTH'(rx_data[3:0]);
`ifdef UART_TOKEN_PARSER_HEX_EN
                        state_d = (rx_data == 8'h30) ? S_PFX : S_DEC;
`else
                        state_d = S_DEC;
`endif
                    end else if (is_term) begin
                        // Empty lines (including the \n of \r\n) vanish.
                        if (cnt_d != '0) state_d = S_HOLD;
                    end else if (!is_sep) begin
                        fail      = 1'b1;
                        fail_code = E_ILL;
                    end
                end
                S_DEC: begin
                    if (is_dig) begin
                        if (dec_ovf) begin
                            fail      = 1'b1;
                            fail_code = E_OVF;
                        end else begin
                            acc_d = dec_ext[VALUE_WIDTH-1:0];
                        end
                    end else if (is_sep || is_term) begin
                        close = 1'b1;
                    end else begin
                        fail      = 1'b1;
                        fail_code = E_ILL;
                    end
                end
`ifdef UART_TOKEN_PARSER_HEX_EN
                S_PFX: begin
                    if (is_x) begin
                        state_d = S_HEX;
                        hexd_d  = 1'b0;
                    end else if (is_dig) begin
                        state_d = S_DEC;
                        acc_d   = VALUE_WIDTH'(rx_data[3:0]);
                    end else if (is_sep || is_term) begin
                        close = 1'b1;
                    end else begin
                        fail      = 1'b1;
                        fail_code = E_ILL;
                    end
                end
                S_HEX: begin
                    if (is_dig || is_alpha) begin
                        hexd_d = 1'b1;
                        if (hex_ovf) begin
                            fail      = 1'b1;
                            fail_code = E_OVF;
                        end else begin
                            acc_d = hex_ext[VALUE_WIDTH-1:0];
                        end
                    end else if ((is_sep || is_term) && hexd_q) begin
                        close = 1'b1;
                    end else begin
                        // Bare "0x" with no digits lands here too.
                        fail      = 1'b1;
                        fail_code = E_ILL;
                    end
                end
`endif
                S_DISCARD: begin
                    if (is_term) state_d = S_HOLD;
                end
                S_HOLD: begin
                    ovr_d = 1'b1;
                end
                default: begin
                    state_d = S_GAP;
                end
            endcase
        end

        if (close) begin
            acc_d = '0;
            if (cnt_q == CW'(MAX_TOKENS)) begin
                fail      = 1'b1;
                fail_code = E_CNT;
            end else begin
                tok_d[int'(cnt_q)*VALUE_WIDTH +: VALUE_WIDTH] = acc_q;
                cnt_d   = cnt_q + CW'(1);
                state_d = S_GAP;
            end
        end

        if (fail) begin
            state_d = S_DISCARD;
            err_d   = 1'b1;
            code_d  = fail_code;
            acc_d   = '0;
        end

        // The terminator that closes a token (or triggers an error)
        // also ends the line; there is no later terminator to wait for.
        if ((close || fail) && is_term) state_d = S_HOLD;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_GAP;
            acc_q   <= '0;
            cnt_q   <= '0;
            tok_q   <= '0;
            err_q   <= 1'b0;
            code_q  <= 2'b00;
            ovr_q   <= 1'b0;
`ifdef UART_TOKEN_PARSER_HEX_EN
            hexd_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            tok_q   <= tok_d;
            err_q   <= err_d;
            code_q  <= code_d;
            ovr_q   <= ovr_d;
`ifdef UART_TOKEN_PARSER_HEX_EN
            hexd_q  <= hexd_d;
`endif
        end
    end

    assign line_valid  = (state_q == S_HOLD);
    assign line_error  = err_q;
    assign err_code    = code_q;
    assign token_count = cnt_q;
    assign tokens      = tok_q;
    assign overrun     = ovr_q;

endmodule

// File: tb/tb_uart_token_parser.sv
// Bench for uart_token_parser: one 16-bit and one 8-bit instance,
// table vectors, hand sequences and random lines against a word model.
module tb_uart_token_parser;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [1:0][7:0] rxd;
    logic [1:0]      rxv;
    logic [1:0]      ack;
    logic [1:0]      lv;
    logic [1:0]      le;
    logic [1:0][1:0] ec;
    logic [1:0][2:0] tc;
    logic [1:0]      ov;
    logic [63:0]     tok0;
    logic [31:0]     tok1;

    int n_tests = 0;
    int n_fail  = 0;

    uart_token_parser #(.MAX_TOKENS(4), .VALUE_WIDTH(16)) u_dut0 (
        .clk(clk), .rst(rst),
        .rx_data(rxd[0]), .rx_valid(rxv[0]),
        .line_valid(lv[0]), .line_ack(ack[0]),
        .line_error(le[0]), .err_code(ec[0]),
        .token_count(tc[0]), .tokens(tok0),
        .overrun(ov[0])
    );

    uart_token_parser #(.MAX_TOKENS(4), .VALUE_WIDTH(8)) u_dut1 (
        .clk(clk), .rst(rst),
        .rx_data(rxd[1]), .rx_valid(rxv[1]),
        .line_valid(lv[1]), .line_ack(ack[1]),
        .line_error(le[1]), .err_code(ec[1]),
        .token_count(tc[1]), .tokens(tok1),
        .overrun(ov[1])
    );

    typedef logic [3:0][31:0] tvec_t;

    typedef struct {
        int         k;
        string      s;
        bit         ev;
        bit         ee;
        logic [1:0] code;
        int         n;
        tvec_t      t;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(int k, string s, bit ev, bit ee,
                                int code, int n, int t0 = 0,
                                int t1 = 0, int t2 = 0, int t3 = 0);
        vec_t v;
        v.k    = k;
        v.s    = s;
        v.ev   = ev;
        v.ee   = ee;
        v.code = code[1:0];
        v.n    = n;
        v.t    = {t3, t2, t1, t0};
        return v;
    endfunction

    task automatic chk(input string nm, input longint act,
                       input longint exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic longint tokv(int k, int i);
        if (k == 0) return longint'(tok0[i*16 +: 16]);
        return longint'(tok1[i*8 +: 8]);
    endfunction

    task automatic send_byte(input int k, input byte b, input int gap);
        rxd[k] = b;
        rxv[k] = 1'b1;
        @(negedge clk);
        rxv[k] = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic send_str(input int k, input string s, input int gap);
        for (int i = 0; i < s.len(); i++) send_byte(k, s[i], gap);
    endtask

    task automatic chk_reset(input string nm);
        for (int k = 0; k < 2; k++) begin
            chk({nm, " line_valid"}, lv[k], 0);
            chk({nm, " line_error"}, le[k], 0);
            chk({nm, " err_code"}, ec[k], 0);
            chk({nm, " token_count"}, tc[k], 0);
            chk({nm, " overrun"}, ov[k], 0);
            for (int i = 0; i < 4; i++)
                chk($sformatf("%s tok%0d", nm, i), tokv(k, i), 0);
        end
    endtask

    // Called at the negedge right after the terminator was sampled.
    task automatic check_line(input int k, input string nm,
                              input bit ev, input bit ee,
                              input logic [1:0] code, input int n,
                              input tvec_t t);
        chk({nm, " line_valid"}, lv[k], ev);
        if (ev) begin
            chk({nm, " line_error"}, le[k], ee);
            chk({nm, " err_code"}, ec[k], code);
            chk({nm, " token_count"}, tc[k], n);
            if (!ee) begin
                for (int i = 0; i < 4; i++)
                    chk($sformatf("%s tok%0d", nm, i),
                        tokv(k, i), longint'(t[i]));
            end
            ack[k] = 1'b1;
            @(negedge clk);
            ack[k] = 1'b0;
            chk({nm, " ack clears"}, lv[k], 0);
        end
    endtask

    // Reference: split the line into words, then judge words in order.
    function automatic void model(input string s, input int vw,
                                  output bit v, output bit e,
                                  output logic [1:0] c, output int n,
                                  output tvec_t t);
        string  w[$];
        string  cur;
        string  ws;
        longint mx;
        longint acc;
        byte    ch;
        mx  = (longint'(1) << vw) - 1;
        e   = 1'b0;
        c   = 2'b00;
        n   = 0;
        t   = '0;
        cur = "";
        for (int i = 0; i < s.len(); i++) begin
            ch = s[i];
            if (ch == 8'h20 || ch == 8'h09) begin
                if (cur.len() > 0) w.push_back(cur);
                cur = "";
            end else begin
                cur = {cur, s.substr(i, i)};
            end
        end
        if (cur.len() > 0) w.push_back(cur);
        for (int k = 0; k < w.size() && !e; k++) begin
            ws  = w[k];
            acc = 0;
            for (int j = 0; j < ws.len() && !e; j++) begin
                ch = ws[j];
                if (ch < 8'h30 || ch > 8'h39) begin
                    e = 1'b1;
                    c = 2'b11;
                end else begin
                    acc = acc * 10 + longint'(ch - 8'h30);
                    if (acc > mx) begin
                        e = 1'b1;
                        c = 2'b01;
                    end
                end
            end
            if (!e) begin
                if (k >= 4) begin
                    e = 1'b1;
                    c = 2'b10;
                end else begin
                    t[k] = acc[31:0];
                    n    = k + 1;
                end
            end
        end
        v = e || (n > 0);
    endfunction

    function automatic string rand_line();
        string s;
        int    len;
        int    r;
        byte   ch;
        s   = "";
        len = $urandom_range(0, 12);
        for (int i = 0; i < len; i++) begin
            r = $urandom_range(0, 19);
            if (r < 12)       ch = byte'(8'h30 + $urandom_range(0, 9));
            else if (r < 15)  ch = 8'h20;
            else if (r < 17)  ch = 8'h09;
            else if (r == 17) ch = 8'h61;
            else if (r == 18) ch = 8'h23;
            else              ch = 8'h30;
            s = {s, $sformatf("%c", ch)};
        end
        return s;
    endfunction

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        string  s;
        bit     ev, ee;
        logic [1:0] code;
        int     n;
        tvec_t  t;
        byte    term;
        int     k;

        rst = 1'b1;
        rxd = '0;
        rxv = '0;
        ack = '0;
        repeat (2) @(negedge clk);
        chk_reset("reset");
        rst = 1'b0;
        @(negedge clk);

        // "2 2\n", bytes five cycles apart.
        send_str(0, "2 2", 5);
        send_byte(0, 8'h0A, 0);
        check_line(0, "spaced", 1, 0, 2'b00, 2, {32'd0, 32'd0, 32'd2, 32'd2});

        // \r ends the line; the following \n is an empty line.
        send_str(0, "  12\t345", 0);
        send_byte(0, 8'h0D, 0);
        check_line(0, "crlf", 1, 0, 2'b00, 2, {32'd0, 32'd0, 32'd345, 32'd12});
        send_byte(0, 8'h0A, 0);
        chk("crlf no second line", lv[0], 0);
        @(negedge clk);
        chk("crlf still idle", lv[0], 0);

        vecs.push_back(mk(0, "007", 1, 0, 0, 1, 7));
        vecs.push_back(mk(0, "65535 0", 1, 0, 0, 2, 65535, 0));
        vecs.push_back(mk(0, "65536", 1, 1, 1, 0));
        vecs.push_back(mk(0, "1 2 3 4", 1, 0, 0, 4, 1, 2, 3, 4));
        vecs.push_back(mk(0, "\t 9  ", 1, 0, 0, 1, 9));
        vecs.push_back(mk(0, "", 0, 0, 0, 0));
        vecs.push_back(mk(0, "   ", 0, 0, 0, 0));
        vecs.push_back(mk(0, "x", 1, 1, 3, 0));
        vecs.push_back(mk(0, "5 99999 x", 1, 1, 1, 1));
        vecs.push_back(mk(1, "255", 1, 0, 0, 1, 255));
        vecs.push_back(mk(1, "256", 1, 1, 1, 0));
        vecs.push_back(mk(1, "1 2 3 4 5", 1, 1, 2, 4));
        vecs.push_back(mk(1, "1a", 1, 1, 3, 0));
        vecs.push_back(mk(1, "1 2 3 4 5a", 1, 1, 3, 4));
        vecs.push_back(mk(1, "0 0 0 0 ", 1, 0, 0, 4));
`ifdef UART_TOKEN_PARSER_HEX_EN
        vecs.push_back(mk(0, "0x1F 010", 1, 0, 0, 2, 31, 10));
        vecs.push_back(mk(0, "0x", 1, 1, 3, 0));
        vecs.push_back(mk(0, "0XfF", 1, 0, 0, 1, 255));
        vecs.push_back(mk(1, "0x100", 1, 1, 1, 0));
`endif
        foreach (vecs[i]) begin
            send_str(vecs[i].k, vecs[i].s, 0);
            send_byte(vecs[i].k, 8'h0A, 0);
            check_line(vecs[i].k, $sformatf("vec%0d", i),
                       vecs[i].ev, vecs[i].ee, vecs[i].code,
                       vecs[i].n, vecs[i].t);
        end

        // Bytes arriving while a line is held are dropped.
        send_str(0, "7", 0);
        send_byte(0, 8'h0A, 0);
        chk("hold valid", lv[0], 1);
        s = "3\r\n";
        for (int i = 0; i < s.len(); i++) begin
            send_byte(0, s[i], 0);
            chk($sformatf("overrun pulse%0d", i), ov[0], 1);
            @(negedge clk);
            chk($sformatf("overrun low%0d", i), ov[0], 0);
        end
        chk("hold still valid", lv[0], 1);
        chk("hold count", tc[0], 1);
        chk("hold tok0", tokv(0, 0), 7);
        ack[0] = 1'b1;
        rxd[0] = 8'h39;
        rxv[0] = 1'b1;
        @(negedge clk);
        ack[0] = 1'b0;
        rxv[0] = 1'b0;
        chk("ack+rx no overrun", ov[0], 0);
        chk("ack+rx released", lv[0], 0);
        send_byte(0, 8'h0A, 0);
        check_line(0, "ack+rx", 1, 0, 2'b00, 1, {32'd0, 32'd0, 32'd0, 32'd9});

        // Reset mid-line on one instance and in hold on the other.
        send_str(1, "5", 0);
        send_byte(1, 8'h0A, 0);
        chk("pre-rst hold", lv[1], 1);
        send_str(0, "12", 0);
        rst = 1'b1;
        @(negedge clk);
        chk_reset("midrst");
        rst = 1'b0;
        send_str(0, "4", 0);
        send_byte(0, 8'h0A, 0);
        check_line(0, "postrst", 1, 0, 2'b00, 1, {32'd0, 32'd0, 32'd0, 32'd4});
        chk("postrst inst1 idle", lv[1], 0);

        for (int it = 0; it < 300; it++) begin
            k    = it % 2;
            s    = rand_line();
            term = ($urandom_range(0, 1) == 1) ? 8'h0A : 8'h0D;
            model(s, (k == 0) ? 16 : 8, ev, ee, code, n, t);
            send_str(k, s, $urandom_range(0, 1));
            send_byte(k, term, 0);
            check_line(k, $sformatf("rand%0d", it), ev, ee, code, n, t);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
